pkt_rr_arbiter: RTL and testbench

Round-robin packet arbiter sharing one downstream packet sink among N_SRC packet sources of the start/EN/data/last generator type. It grants one source at a time and forwards that source's beats unchanged, one cycle later, until the source's last beat, then rotates priority. It sits between the bank of packet generators and the single packet consumer.

---
 rtl/pkt_arb_pkg.sv | 26 ++
 rtl/pkt_rr_arbiter_if.sv | 31 +++
 rtl/pkt_rr_arbiter_rr_pick.sv | 39 +++
 rtl/pkt_rr_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_pkt_rr_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pkt_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
package pkt_arb_pkg;

    // Arbiter FSM states: waiting for a winner, or forwarding one packet.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int DEF_N_SRC   = 4;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 255;

    // Width of a source index; at least one bit even for degenerate counts.
    function automatic int src_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Watchdog counter width: wide enough for the timeout, never below 8 bits.
    function automatic int wd_cnt_w(input int t);
        int w;
        w = $clog2(t + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/pkt_rr_arbiter_if.sv
// Source-bank / sink bundle for pkt_rr_arbiter.
// slave  : arbiter side (consumes requests and beats, drives grant and out_*).
// master : environment side (packet generators and sink).
interface pkt_rr_arbiter_if #(
    parameter int N_SRC  = pkt_arb_pkg::DEF_N_SRC,
    parameter int DATA_W = pkt_arb_pkg::DEF_DATA_W
) ();
    localparam int IDX_W = pkt_arb_pkg::src_idx_w(N_SRC);

    logic [N_SRC-1:0]        src_req;
    logic [N_SRC-1:0]        src_en;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_last;
    logic                    sink_ready;
    logic [N_SRC-1:0]        src_grant;
    logic                    out_en;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic [IDX_W-1:0]        out_src;
    logic                    out_abort;

    modport slave (
        input  src_req, src_en, src_data, src_last, sink_ready,
        output src_grant, out_en, out_data, out_last, out_src, out_abort
    );

    modport master (
        output src_req, src_en, src_data, src_last, sink_ready,
        input  src_grant, out_en, out_data, out_last, out_src, out_abort
    );
endinterface

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after last_winner,
// wrapping modulo N_SRC.
module rr_pick
    import pkt_arb_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC,
    parameter int IDX_W = src_idx_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] last_winner_i,
    output logic [N_SRC-1:0] pick_o,
    output logic [IDX_W-1:0] pick_idx_o,
    output logic             any_req_o
);
    int               cand_int_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // Scan from last_winner+1 upward so the previous winner is checked last.
    always_comb begin
        pick_o     = '0;
        pick_idx_o = '0;
        any_req_o  = |req_i;
        found_s    = 1'b0;
        cand_int_s = 0;
        cand_s     = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            cand_int_s = (int'(last_winner_i) + i) % N_SRC;
            cand_s     = IDX_W'(cand_int_s);
            if (!found_s && req_i[cand_s]) begin
                found_s        = 1'b1;
                pick_o[cand_s] = 1'b1;
                pick_idx_o     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/pkt_rr_arbiter.sv
// Round-robin packet arbiter: grants one source at a time and forwards its
// beats one cycle late until its last beat, then rotates priority.
// Optional build macro PKT_ARB_WATCHDOG_EN adds a stall watchdog that aborts
// a granted packet after TIMEOUT consecutive beat-less cycles.
module pkt_rr_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int N_SRC   = DEF_N_SRC,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    pkt_rr_arbiter_if.slave   arb
);
    localparam int IDX_W = src_idx_w(N_SRC);

    // Reject unusable configurations at elaboration time.
    if (N_SRC < 2 || N_SRC > 16 || TIMEOUT < 1) begin : g_bad_cfg
        $error("pkt_rr_arbiter: N_SRC must be 2..16 and TIMEOUT >= 1");
    end

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [IDX_W-1:0]  last_winner_q, last_winner_d;
    logic [N_SRC-1:0]  grant_q, grant_d;
    logic              out_en_q, out_en_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [IDX_W-1:0]  out_src_q, out_src_d;

    logic [N_SRC-1:0]  pick_s;
    logic [IDX_W-1:0]  pick_idx_s;
    logic              any_req_s;
    logic              cur_en_s;
    logic              cur_last_s;
    logic [DATA_W-1:0] cur_data_s;

`ifdef PKT_ARB_WATCHDOG_EN
    localparam int WD_W = wd_cnt_w(TIMEOUT);
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              out_abort_q, out_abort_d;
`endif

    rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i         (arb.src_req),
        .last_winner_i (last_winner_q),
        .pick_o        (pick_s),
        .pick_idx_o    (pick_idx_s),
        .any_req_o     (any_req_s)
    );

    assign cur_en_s   = arb.src_en[cur_q];
    assign cur_last_s = arb.src_last[cur_q];

    // Select the granted source's data lane; other lanes never reach the output.
    always_comb begin
        cur_data_s = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (cur_q == IDX_W'(k)) begin
                cur_data_s = arb.src_data[k*DATA_W +: DATA_W];
            end else begin
                cur_data_s = cur_data_s;
            end
        end
    end

    // Next-state and registered-output logic for the grant FSM.
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        last_winner_d = last_winner_q;
        grant_d       = grant_q;
        out_en_d      = 1'b0;
        out_data_d    = out_data_q;
        out_last_d    = 1'b0;
        out_src_d     = out_src_q;
`ifdef PKT_ARB_WATCHDOG_EN
        wd_d          = wd_q;
        out_abort_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (arb.sink_ready && any_req_s) begin
                    grant_d = pick_s;
                    cur_d   = pick_idx_s;
                    state_d = BUSY;
`ifdef PKT_ARB_WATCHDOG_EN
                    wd_d    = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                out_en_d   = cur_en_s;
                out_last_d = cur_en_s & cur_last_s;
                out_src_d  = cur_q;
                if (cur_en_s) begin
                    out_data_d = cur_data_s;
`ifdef PKT_ARB_WATCHDOG_EN
                    wd_d       = '0;
`endif
                    if (cur_last_s) begin
                        grant_d       = '0;
                        last_winner_d = cur_q;
                        state_d       = IDLE;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
`ifdef PKT_ARB_WATCHDOG_EN
                    // This beat-less cycle is the TIMEOUT-th in a row: abort.
                    if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        grant_d       = '0;
                        last_winner_d = cur_q;
                        out_abort_d   = 1'b1;
                        wd_d          = '0;
                        state_d       = IDLE;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
`else
                    state_d = BUSY;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers; last_winner resets so source 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_q         <= '0;
            last_winner_q <= IDX_W'(N_SRC - 1);
            grant_q       <= '0;
            out_en_q      <= 1'b0;
            out_data_q    <= '0;
            out_last_q    <= 1'b0;
            out_src_q     <= '0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            last_winner_q <= last_winner_d;
            grant_q       <= grant_d;
            out_en_q      <= out_en_d;
            out_data_q    <= out_data_d;
            out_last_q    <= out_last_d;
            out_src_q     <= out_src_d;
        end
    end

`ifdef PKT_ARB_WATCHDOG_EN
    // Watchdog counter and abort pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q        <= '0;
            out_abort_q <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            out_abort_q <= out_abort_d;
        end
    end

    assign arb.out_abort = out_abort_q;
`else
    assign arb.out_abort = 1'b0;
`endif

    assign arb.src_grant = grant_q;
    assign arb.out_en    = out_en_q;
    assign arb.out_data  = out_data_q;
    assign arb.out_last  = out_last_q;
    assign arb.out_src   = out_src_q;
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed-vector bench for pkt_rr_arbiter (N_SRC=4, DATA_W=8, TIMEOUT=4).
module tb_pkt_rr_arbiter;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    pkt_rr_arbiter_if #(.N_SRC(4), .DATA_W(8)) bif ();

    pkt_rr_arbiter #(
        .N_SRC   (4),
        .DATA_W  (8),
        .TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         do_rst;
        logic [3:0] req;
        logic [3:0] en;
        logic [3:0] last;
        logic [31:0] data;
        logic       ready;
        logic [3:0] e_grant;
        logic       e_en;
        logic [7:0] e_data;
        logic       e_last;
        logic [1:0] e_src;
        logic       e_abort;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input bit rs, input logic [3:0] rq, input logic [3:0] en,
                                input logic [3:0] la, input logic [31:0] d, input logic rdy,
                                input logic [3:0] eg, input logic ee, input logic [7:0] ed,
                                input logic el, input logic [1:0] es, input logic ea);
        vec_t v;
        v.do_rst = rs; v.req = rq; v.en = en; v.last = la; v.data = d; v.ready = rdy;
        v.e_grant = eg; v.e_en = ee; v.e_data = ed; v.e_last = el; v.e_src = es; v.e_abort = ea;
        vq.push_back(v);
    endfunction

    task automatic drive(input logic [3:0] rq, input logic [3:0] en, input logic [3:0] la,
                         input logic [31:0] d, input logic rdy);
        bif.src_req    = rq;
        bif.src_en     = en;
        bif.src_last   = la;
        bif.src_data   = d;
        bif.sink_ready = rdy;
    endtask

    task automatic cyc(input logic [3:0] rq, input logic [3:0] en, input logic [3:0] la,
                       input logic [31:0] d, input logic rdy);
        drive(rq, en, la, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1);
        #1;
        rst = 1'b0;
    endtask

    task automatic check(input int tag, input logic [3:0] eg, input logic ee, input logic [7:0] ed,
                         input logic el, input logic [1:0] es, input logic ea);
        n_vec++;
        if ({bif.src_grant, bif.out_en, bif.out_data, bif.out_last, bif.out_src, bif.out_abort}
            !== {eg, ee, ed, el, es, ea}) begin
            n_bad++;
            $display("FAIL vec%0d: got grant=%b en=%b data=%h last=%b src=%0d abort=%b, want grant=%b en=%b data=%h last=%b src=%0d abort=%b",
                     tag, bif.src_grant, bif.out_en, bif.out_data, bif.out_last, bif.out_src,
                     bif.out_abort, eg, ee, ed, el, es, ea);
        end
    endtask

    initial begin
        int order [5];
        logic [7:0] pd;
        logic [1:0] ps;
        logic [3:0] m;
        n_vec = 0;
        n_bad = 0;

        // Basic 3-beat packet from source 0 (one generator delay cycle after grant).
        add(1, 4'b0001, 4'b0000, 4'b0000, 32'h00, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        add(0, 4'b0001, 4'b0000, 4'b0000, 32'h00, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        add(0, 4'b0001, 4'b0001, 4'b0000, 32'h00, 1'b1, 4'b0001, 1'b1, 8'h00, 1'b0, 2'd0, 1'b0);
        add(0, 4'b0001, 4'b0001, 4'b0000, 32'h01, 1'b1, 4'b0001, 1'b1, 8'h01, 1'b0, 2'd0, 1'b0);
        add(0, 4'b0001, 4'b0001, 4'b0001, 32'h02, 1'b1, 4'b0000, 1'b1, 8'h02, 1'b1, 2'd0, 1'b0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h00, 1'b1, 4'b0000, 1'b0, 8'h02, 1'b0, 2'd0, 1'b0);

        // All sources requesting: grants rotate 0,1,2,3,0 with one idle cycle between.
        order = '{0, 1, 2, 3, 0};
        pd = 8'h00;
        ps = 2'd0;
        for (int p = 0; p < 5; p++) begin
            m = 4'b0001 << order[p];
            add(p == 0, 4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b1, m, 1'b0, pd, 1'b0, ps, 1'b0);
            add(0, 4'b1111, m, 4'b0000, 32'h30201000, 1'b1, m, 1'b1, 8'(order[p] * 16), 1'b0,
                2'(order[p]), 1'b0);
            add(0, 4'b1111, m, m, 32'h31211101, 1'b1, 4'b0000, 1'b1, 8'(order[p] * 16 + 1), 1'b1,
                2'(order[p]), 1'b0);
            pd = 8'(order[p] * 16 + 1);
            ps = 2'(order[p]);
        end
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, pd, 1'b0, ps, 1'b0);

        // Source 2 granted while sources 0 and 1 chatter with 0xAA.
        add(1, 4'b0100, 4'b0011, 4'b0000, 32'h0055AAAA, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        add(0, 4'b0100, 4'b0011, 4'b0011, 32'h0055AAAA, 1'b1, 4'b0100, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0);
        add(0, 4'b0100, 4'b0111, 4'b0000, 32'h005AAAAA, 1'b1, 4'b0100, 1'b1, 8'h5A, 1'b0, 2'd2, 1'b0);
        add(0, 4'b0100, 4'b0111, 4'b0111, 32'h005BAAAA, 1'b1, 4'b0000, 1'b1, 8'h5B, 1'b1, 2'd2, 1'b0);
        add(0, 4'b0000, 4'b0011, 4'b0000, 32'h0000AAAA, 1'b1, 4'b0000, 1'b0, 8'h5B, 1'b0, 2'd2, 1'b0);

        // sink_ready low blocks the grant; then a single-beat packet.
        for (int i = 0; i < 10; i++) begin
            add(i == 0, 4'b0010, 4'b0000, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        end
        add(0, 4'b0010, 4'b0000, 4'b0000, 32'h0, 1'b1, 4'b0010, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        add(0, 4'b0010, 4'b0010, 4'b0010, 32'h00007700, 1'b1, 4'b0000, 1'b1, 8'h77, 1'b1, 2'd1, 1'b0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 8'h77, 1'b0, 2'd1, 1'b0);

        // Reset state.
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b1);
        #3;
        check(0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        #4;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].do_rst) pulse_rst();
            drive(vq[i].req, vq[i].en, vq[i].last, vq[i].data, vq[i].ready);
            @(posedge clk);
            #1;
            check(i + 1, vq[i].e_grant, vq[i].e_en, vq[i].e_data, vq[i].e_last, vq[i].e_src,
                  vq[i].e_abort);
        end

        // Reset during beat 2 of a 5-beat packet from source 0.
        pulse_rst();
        cyc(4'b0001, 4'b0000, 4'b0000, 32'h0, 1'b1);
        check(200, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        cyc(4'b0001, 4'b0001, 4'b0000, 32'h10, 1'b1);
        check(201, 4'b0001, 1'b1, 8'h10, 1'b0, 2'd0, 1'b0);
        cyc(4'b0001, 4'b0001, 4'b0000, 32'h11, 1'b1);
        check(202, 4'b0001, 1'b1, 8'h11, 1'b0, 2'd0, 1'b0);
        drive(4'b0001, 4'b0001, 4'b0000, 32'h12, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check(203, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        rst = 1'b0;
        cyc(4'b1111, 4'b0000, 4'b0000, 32'h0, 1'b1);
        check(204, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);

        // Source 0 sends one beat then stalls; source 1 waits.
        pulse_rst();
        cyc(4'b0011, 4'b0000, 4'b0000, 32'h0, 1'b1);
        check(300, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0);
        cyc(4'b0011, 4'b0001, 4'b0000, 32'h42, 1'b1);
        check(301, 4'b0001, 1'b1, 8'h42, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0011, 4'b0000, 4'b0000, 32'h0, 1'b1);
            check(302 + k, 4'b0001, 1'b0, 8'h42, 1'b0, 2'd0, 1'b0);
        end
        cyc(4'b0011, 4'b0000, 4'b0000, 32'h0, 1'b1);
`ifdef PKT_ARB_WATCHDOG_EN
        check(305, 4'b0000, 1'b0, 8'h42, 1'b0, 2'd0, 1'b1);
`else
        check(305, 4'b0001, 1'b0, 8'h42, 1'b0, 2'd0, 1'b0);
`endif
        cyc(4'b0011, 4'b0000, 4'b0000, 32'h0, 1'b1);
`ifdef PKT_ARB_WATCHDOG_EN
        check(306, 4'b0010, 1'b0, 8'h42, 1'b0, 2'd0, 1'b0);
`else
        check(306, 4'b0001, 1'b0, 8'h42, 1'b0, 2'd0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
